// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game engine.
// Game/phase enums, LFSR taps and score clamping.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_e;

    typedef enum logic {
        DOWN,
        UP
    } phase_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Adds a signed delta and clamps to [0, 2^width-1].
    function automatic logic [63:0] sat_add(
        input logic signed [63:0] base,
        input logic signed [63:0] delta,
        input int unsigned        width
    );
        logic signed [63:0] sum;
        logic signed [63:0] top;
        sum = base + delta;
        top = (64'sd1 <<< width) - 64'sd1;
        if (sum < 0) begin
            return '0;
        end else if (sum > top) begin
            return top;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/mole_game_core_if.sv
// Board-side bundle of the game engine: raw buttons in,
// lamps, score, status and event pulses out.
interface mole_game_core_if #(
    parameter int N_CH    = 4,
    parameter int SCORE_W = 16
);
    logic [N_CH-1:0]    btn_n;
    logic               start_n;
    logic [N_CH-1:0]    lamp;
    logic [SCORE_W-1:0] score;
    logic               in_game;
    logic               game_over;
    logic [N_CH-1:0]    hit_pulse;
    logic [N_CH-1:0]    miss_pulse;

    modport master (
        output btn_n, start_n,
        input  lamp, score, in_game, game_over,
        input  hit_pulse, miss_pulse
    );

    modport slave (
        input  btn_n, start_n,
        output lamp, score, in_game, game_over,
        output hit_pulse, miss_pulse
    );
endinterface

// File: rtl/mole_channel.sv
// One mole: DOWN/UP phase timer, lamp, hit/miss detection.
// hit/miss are combinational for the score adder; pulses are registered.
module mole_channel
    import mole_pkg::*;
#(
    parameter int               CNT_W  = 32,
    parameter logic [CNT_W-1:0] ON_CYC = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play,
    input  logic             enter_play,
    input  logic [CNT_W-1:0] off_len,
    input  logic             evt,
    output logic             lamp,
    output logic             hit,
    output logic             miss,
    output logic             hit_pulse,
    output logic             miss_pulse
);

    phase_e           phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] off_q;

    assign hit  = play && (phase_q == UP) && evt;
    assign miss = play && (phase_q == UP) && !evt &&
                  (cnt_q == ON_CYC - 1'b1);

    // Phase timer: hit beats timeout; leaving PLAY parks the mole down.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= DOWN;
            cnt_q      <= '0;
            off_q      <= '0;
            lamp       <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= hit;
            miss_pulse <= miss;
            if (enter_play) begin
                phase_q <= DOWN;
                cnt_q   <= '0;
                off_q   <= off_len;
                lamp    <= 1'b0;
            end else if (!play) begin
                phase_q <= DOWN;
                cnt_q   <= '0;
                lamp    <= 1'b0;
            end else if (hit || miss) begin
                phase_q <= DOWN;
                cnt_q   <= '0;
                off_q   <= off_len;
                lamp    <= 1'b0;
            end else if (phase_q == DOWN) begin
                if (cnt_q == off_q - 1'b1) begin
                    phase_q <= UP;
                    cnt_q   <= '0;
                    lamp    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole engine: input sync, LFSR, game FSM, timer, score.
// Optional MOLE_WRONG_PRESS_PENALTY_EN: a press on a down mole costs 1.
module mole_game_core
    import mole_pkg::*;
#(
    parameter int               N_CH      = 4,
    parameter int               SCORE_W   = 16,
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] ON_CYC    = 100000000,
    parameter logic [CNT_W-1:0] OFF_MIN   = 50000000,
    parameter logic [31:0]      OFF_MASK  = 32'h0FFF_FFFF,
    parameter logic [CNT_W-1:0] GAME_CYC  = CNT_W'(64'd3000000000),
    parameter logic [31:0]      LFSR_SEED = 32'hACE1_1234
) (
    input logic            clk,
    input logic            reset,
    mole_game_core_if.slave bus
);

    localparam int SUM_W = SCORE_W + N_CH + 1;

    logic [N_CH-1:0]    btn_s1, btn_s2, btn_s3;
    logic               start_s1, start_s2, start_s3;
    logic [N_CH-1:0]    btn_evt;
    logic               start_evt;
    logic [31:0]        lfsr_q;
    logic [CNT_W-1:0]   off_len;
    game_state_e        state_q, state_d;
    logic               enter_play;
    logic               in_play;
    logic [CNT_W-1:0]   timer_q;
    logic               timer_done;
    logic [N_CH-1:0]    lamp_raw, hit, miss, hit_p, miss_p;
    logic signed [SUM_W-1:0] delta;
    logic [SCORE_W-1:0] score_q, score_d;

    // Two-flop synchronisers plus history flop; idle level is released (1).
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= '1;
            btn_s2   <= '1;
            btn_s3   <= '1;
            start_s1 <= 1'b1;
            start_s2 <= 1'b1;
            start_s3 <= 1'b1;
        end else begin
            btn_s1   <= bus.btn_n;
            btn_s2   <= btn_s1;
            btn_s3   <= btn_s2;
            start_s1 <= bus.start_n;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
        end
    end

    assign btn_evt   = btn_s3 & ~btn_s2;
    assign start_evt = start_s3 & ~start_s2;

    // Free-running Galois LFSR for the lamp-off jitter.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= (lfsr_q >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

    assign off_len = OFF_MIN + (CNT_W'(lfsr_q) & CNT_W'(OFF_MASK));

    assign in_play    = (state_q == PLAY);
    assign timer_done = (timer_q == GAME_CYC - 1'b1);

    // Game state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start launches a game, the timer ends it.
    always_comb begin
        state_d    = state_q;
        enter_play = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start_evt) begin
                    state_d    = PLAY;
                    enter_play = 1'b1;
                end
            end
            PLAY: begin
                if (timer_done) begin
                    state_d = OVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Game timer runs only in PLAY and is cleared otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (in_play && !timer_done) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mole_channel #(
            .CNT_W  (CNT_W),
            .ON_CYC (ON_CYC)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .play       (in_play),
            .enter_play (enter_play),
            .off_len    (off_len),
            .evt        (btn_evt[g]),
            .lamp       (lamp_raw[g]),
            .hit        (hit[g]),
            .miss       (miss[g]),
            .hit_pulse  (hit_p[g]),
            .miss_pulse (miss_p[g])
        );
    end

    // Net score change this cycle across all channels.
    always_comb begin
        delta = '0;
        for (int i = 0; i < N_CH; i++) begin
            delta = delta + SUM_W'(hit[i]) - SUM_W'(miss[i]);
`ifdef MOLE_WRONG_PRESS_PENALTY_EN
            delta = delta - SUM_W'(in_play & btn_evt[i] & ~lamp_raw[i]);
`endif
        end
    end

    assign score_d = SCORE_W'(sat_add(64'(score_q), 64'(delta), SCORE_W));

    // Score clears on game entry, tracks in PLAY, freezes otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else if (enter_play) begin
            score_q <= '0;
        end else if (in_play) begin
            score_q <= score_d;
        end
    end

    assign bus.lamp       = lamp_raw & {N_CH{in_play}};
    assign bus.score      = score_q;
    assign bus.in_game    = in_play;
    assign bus.game_over  = (state_q == OVER);
    assign bus.hit_pulse  = hit_p;
    assign bus.miss_pulse = miss_p;

endmodule

// File: doc/mole_game_core.md
Name: mole_game_core

Overview:
- Parametrised N-channel whack-a-mole game engine: per-channel lamp timers, button hit detection, saturating score, whole-game timer, and an IDLE/PLAY/OVER state machine.
- Sits between board buttons/lamps and the VGA score display.
- Successor to the fixed 4-button game loop: channel count, timings and score width are parameters; adds pseudo-random lamp-off times, miss penalties, a game timer and hit/miss event pulses.

Parameters:
N_CH, 4, number of button/lamp channels (1..16)
SCORE_W, 16, score width
CNT_W, 32, width of all cycle counters
ON_CYC, 100000000, cycles a lamp stays up before it counts as a miss
OFF_MIN, 50000000, minimum cycles a lamp stays down
OFF_MASK, 32'h0FFFFFFF, mask on the LFSR value added to OFF_MIN (0 = deterministic)
GAME_CYC, 3000000000, length of one game in cycles
LFSR_SEED, 32'hACE1_1234, non-zero LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_n  in  N_CH  raw active-low buttons, asynchronous to clk
start_n  in  1  raw active-low start button
lamp  out  N_CH  1 = mole up (lamp lit)
score  out  SCORE_W  current score, unsigned
in_game  out  1  high in PLAY
game_over  out  1  high in OVER
hit_pulse  out  N_CH  one-cycle pulse per channel hit
miss_pulse  out  N_CH  one-cycle pulse per channel timeout

Behaviour:
- Reset: state IDLE; lamp=0, score=0, in_game=0, game_over=0, pulses=0, all counters=0, LFSR=LFSR_SEED, sync flops=1 (released). Reset mid-game returns to IDLE the same edge.
- Input conditioning: btn_n and start_n each pass through a 2-flop synchroniser plus a history flop. An event is a falling edge of the synchronised signal. Level holds never retrigger.
- Latency: a raw fall before edge k gives updated lamp, score and pulse after edge k+2.
- LFSR: 32-bit Galois, taps 0x80200003. Advances every cycle in every state. off_len = OFF_MIN + (lfsr & OFF_MASK), sampled when a channel enters DOWN.
- FSM:
  - IDLE: start event -> PLAY.
  - PLAY: game timer reaches GAME_CYC-1 -> OVER.
  - OVER: start event -> PLAY.
- Entering PLAY: score=0, game timer=0, every channel enters DOWN with counter=0 and a fresh off_len (all channels sample the same LFSR value that cycle).
- Channel in PLAY, DOWN phase: counter counts to off_len-1, then UP with lamp=1 and counter=0.
- Channel in PLAY, UP phase:
  - Button event -> hit: lamp=0, hit_pulse=1, score+1, re-enter DOWN.
  - Counter reaches ON_CYC-1 with no event -> miss: lamp=0, miss_pulse=1, score-1, re-enter DOWN.
  - Hit and timeout on the same cycle: hit wins.
- Score update per cycle: score + popcount(hits) - popcount(misses) (plus penalties, see Optional Feature). Computed in SCORE_W+N_CH+1 signed bits, clamped to [0, 2^SCORE_W-1].
- OVER/IDLE: lamps 0, channel counters held at 0, score frozen (OVER) or 0 (IDLE), button events ignored.
- Start event while in PLAY is ignored.
- Game timer and PLAY->OVER on the same cycle as a hit: the hit is scored, then OVER is entered.

Optional Feature:
- Macro: MOLE_WRONG_PRESS_PENALTY_EN.
- Defined: a button event on a DOWN channel during PLAY subtracts 1, clamped at 0 and combined in the same per-cycle sum. No pulse is generated and the channel timer is unaffected.
- Undefined: DOWN-phase presses are ignored.

Decomposition:
- Package mole_pkg holds:
  - game_state_e {IDLE, PLAY, OVER}
  - phase_e {DOWN, UP}
  - LFSR_TAPS constant
  - saturating add function
- Sub-module mole_channel (one per channel via generate) holds the counter, phase, lamp, and hit/miss detection. Inputs: off_len, event, play, enter_play.
- Top level holds the synchronisers, LFSR, FSM, game timer and score adder.

Test Plan:
All scenarios use N_CH=2, ON_CYC=10, OFF_MIN=5, OFF_MASK=0, GAME_CYC=200, SCORE_W=4.
- Reset then start_n pulse -> in_game=1 at start edge+3. lamp[0]=1 exactly 5 cycles later. No hit -> lamp[0] falls after 10 cycles, miss_pulse[0]=1 for 1 cycle, score stays 0 (floor).
- Press btn_n[0] on the 3rd cycle of UP -> score=1 and hit_pulse[0] 3 edges after the press, lamp[0]=0. Holding the button low produces no second hit.
- Both channels hit on the same cycle -> score +2 in one step. One hit plus one miss on the same cycle -> score unchanged.
- 20 consecutive hits with SCORE_W=4 -> score saturates at 15, no wrap. Misses from 0 stay at 0.
- Game timer reaches 200 -> in_game=0, game_over=1, lamps 0, score frozen. Start event -> PLAY with score 0. Assert reset mid-PLAY -> IDLE next edge with all outputs 0.
- With MOLE_WRONG_PRESS_PENALTY_EN: score 3, press during DOWN -> score 2, no pulse. Without the macro: score stays 3.
